ped_crossing_ctrl: RTL and testbench
====================================

// Module: ped_crossing_ctrl
// PURPOSE
//  Pedestrian crossing controller, downstream of the vehicle traffic-light FSM.
//  Consumes the one-hot vehicle light code and a push-button, and drives the WALK
//  and DONT_WALK lamps. WALK is granted only when the vehicle light enters RED.
//  A walk phase is followed by a flashing clearance phase.
//  Any illegal light code forces a safe (DONT_WALK solid) fault state.
// PARAMETERS
//  WALK_CYC   4  WALK duration in clk cycles (>=1)
//  CLEAR_CYC  3  flashing clearance duration in clk cycles (>=1)
//  FLASH_DIV  1  clk cycles per flash half-period during CLEAR (>=1)
//  CW         8  countdown width; must hold max(WALK_CYC,CLEAR_CYC)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  light      in   3   vehicle light: RED=3'b100, GREEN=3'b010, YELLOW=3'b001
//  ped_btn    in   1   pedestrian button, level; rising edge = request
//  walk       out  1   WALK lamp
//  dont_walk  out  1   DONT_WALK lamp (toggles during CLEAR)
//  flash      out  1   1 while in CLEAR
//  req_pending out 1   latched request awaiting service
//  countdown  out  CW  remaining cycles of WALK/CLEAR, else 0
//  fault      out  1   1 while in FAULT
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, walk=0, dont_walk=1, flash=0,
//    req_pending=0, countdown=0, fault=0, light_q=RED, btn_q=1 (no false edge).
//  - btn_rise = ped_btn & ~btn_q. red_entry = (light==RED) & (light_q!=RED).
//  - legal = light is exactly RED, GREEN or YELLOW. Checked every cycle, all states.
//  - States and transitions, evaluated at each posedge:
//    IDLE:  btn_rise sets req_pending. If (req_pending|btn_rise) & red_entry ->
//           WALK next cycle; req_pending cleared.
//    WALK:  walk=1, dont_walk=0. countdown loaded WALK_CYC on entry, then -1/cycle.
//           Lasts exactly WALK_CYC cycles, then -> CLEAR.
//    CLEAR: walk=0, flash=1. dont_walk=1 on entry, toggles every FLASH_DIV cycles.
//           countdown loaded CLEAR_CYC, then -1/cycle.
//           After CLEAR_CYC cycles -> IDLE (dont_walk=1, flash=0, countdown=0).
//    FAULT: walk=0, dont_walk=1, flash=0, countdown=0, fault=1.
//           Stays while !legal; first legal cycle -> IDLE.
//  - Abort: in WALK or CLEAR, if light!=RED (but legal) -> IDLE next cycle,
//    walk=0, dont_walk=1 solid.
//  - !legal in any state -> FAULT next cycle. Priority: FAULT > abort > timer.
//  - btn_rise during WALK/CLEAR/FAULT sets req_pending; served at a later red_entry.
//    Presses while req_pending=1 have no effect (single request).
//  - Simultaneous btn_rise and red_entry in IDLE: served (WALK next cycle).
//  - Request arriving mid-RED (no red_entry) waits for the next red_entry.
//  - rst mid-phase: next cycle equals the reset state, pending request dropped.
//  - Invariant: walk & dont_walk never both 1; walk=1 only if light_q==RED.
// TESTING
//  1 rst; light GREEN; press btn; YELLOW; RED held 10 cyc -> walk=1 for 4 cyc,
//    countdown 4,3,2,1; then flash=1, dont_walk 1,0,1 for 3 cyc; then IDLE.
//  2 No press; light cycles G->Y->R x3 -> walk stays 0, dont_walk=1 throughout.
//  3 Press during RED (already red) -> req_pending=1, no WALK. Next R entry -> WALK.
//  4 In WALK cycle 2, light->GREEN -> next cycle walk=0, dont_walk=1, IDLE, countdown=0.
//  5 light=3'b110 for 2 cyc in WALK -> fault=1, walk=0.
//    light=RED -> IDLE, fault=0; request not re-served without new red_entry.
//  6 btn_rise in same cycle as red_entry -> WALK next cycle.
//    Assert rst during CLEAR -> reset values next cycle.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing_ctrl
// Description : Pedestrian crossing controller that sits downstream of the
//               vehicle traffic-light FSM. It watches the one-hot vehicle
//               light code and a push-button, and drives the WALK / DONT_WALK
//               lamps. WALK is granted only on entry into vehicle RED, is
//               followed by a flashing clearance phase, and any illegal light
//               code forces a safe DONT_WALK-solid fault state.
// Ports       : clk         - rising-edge clock
//               rst         - synchronous reset, active-high
//               light[2:0]  - vehicle light, RED=100 GREEN=010 YELLOW=001
//               ped_btn     - pedestrian button level (rising edge = request)
//               walk        - WALK lamp
//               dont_walk   - DONT_WALK lamp (toggles during clearance)
//               flash       - high while in clearance
//               req_pending - latched request awaiting service
//               countdown   - remaining cycles of WALK/CLEAR, else 0
//               fault       - high while in fault state
// Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing_ctrl #(
    parameter int WALK_CYC  = 4,
    parameter int CLEAR_CYC = 3,
    parameter int FLASH_DIV = 1,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    light,
    input  logic          ped_btn,
    output logic          walk,
    output logic          dont_walk,
    output logic          flash,
    output logic          req_pending,
    output logic [CW-1:0] countdown,
    output logic          fault
);

    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_GREEN  = 3'b010;
    localparam logic [2:0] c_YELLOW = 3'b001;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WALK  = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [CW-1:0] c_WALK_LOAD = CW'(WALK_CYC);
    localparam logic [CW-1:0] c_CLR_LOAD  = CW'(CLEAR_CYC);

    localparam int                c_FDW       = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_FDW-1:0]  c_FDIV_LAST = c_FDW'(FLASH_DIV - 1);

    logic [1:0]       r_state,  w_state_nxt;
    logic [CW-1:0]    r_cnt,    w_cnt_nxt;
    logic [c_FDW-1:0] r_fdiv,   w_fdiv_nxt;
    logic             r_walk,   w_walk_nxt;
    logic             r_dw,     w_dw_nxt;
    logic             r_flash,  w_flash_nxt;
    logic             r_req,    w_req_nxt;
    logic             r_fault,  w_fault_nxt;
    logic [2:0]       r_light_q;
    logic             r_btn_q;

    logic w_btn_rise;
    logic w_red_entry;
    logic w_legal;
    logic w_is_red;

    assign w_btn_rise  = ped_btn & ~r_btn_q;
    assign w_is_red    = (light == c_RED);
    assign w_red_entry = w_is_red & (r_light_q != c_RED);
    assign w_legal     = (light == c_RED) | (light == c_GREEN) | (light == c_YELLOW);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fdiv_nxt  = r_fdiv;
        w_walk_nxt  = r_walk;
        w_dw_nxt    = r_dw;
        w_flash_nxt = r_flash;
        w_fault_nxt = r_fault;
        // A press is latched in every state; IDLE clears it when served.
        w_req_nxt   = r_req | w_btn_rise;

        if (!w_legal) begin
            w_state_nxt = c_ST_FAULT;
            w_walk_nxt  = 1'b0;
            w_dw_nxt    = 1'b1;
            w_flash_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_fault_nxt = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if ((r_req | w_btn_rise) & w_red_entry) begin
                        w_state_nxt = c_ST_WALK;
                        w_walk_nxt  = 1'b1;
                        w_dw_nxt    = 1'b0;
                        w_cnt_nxt   = c_WALK_LOAD;
                        w_req_nxt   = 1'b0;
                    end
                end
                c_ST_WALK: begin
                    if (!w_is_red) begin
                        w_state_nxt = c_ST_IDLE;
                        w_walk_nxt  = 1'b0;
                        w_dw_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_ONE) begin
                        w_state_nxt = c_ST_CLEAR;
                        w_walk_nxt  = 1'b0;
                        w_dw_nxt    = 1'b1;
                        w_flash_nxt = 1'b1;
                        w_cnt_nxt   = c_CLR_LOAD;
                        w_fdiv_nxt  = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - c_ONE;
                    end
                end
                c_ST_CLEAR: begin
                    if (!w_is_red || (r_cnt == c_ONE)) begin
                        w_state_nxt = c_ST_IDLE;
                        w_dw_nxt    = 1'b1;
                        w_flash_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                        // Lamp holds each level for FLASH_DIV cycles.
                        if (r_fdiv == c_FDIV_LAST) begin
                            w_fdiv_nxt = '0;
                            w_dw_nxt   = ~r_dw;
                        end else begin
                            w_fdiv_nxt = r_fdiv + 1'b1;
                        end
                    end
                end
                default: begin
                    // Fault: leave on the first legal code, never straight to WALK.
                    w_state_nxt = c_ST_IDLE;
                    w_fault_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_fdiv    <= '0;
            r_walk    <= 1'b0;
            r_dw      <= 1'b1;
            r_flash   <= 1'b0;
            r_req     <= 1'b0;
            r_fault   <= 1'b0;
            r_light_q <= c_RED;
            // Held high so a button already pressed at reset is not an edge.
            r_btn_q   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_fdiv    <= w_fdiv_nxt;
            r_walk    <= w_walk_nxt;
            r_dw      <= w_dw_nxt;
            r_flash   <= w_flash_nxt;
            r_req     <= w_req_nxt;
            r_fault   <= w_fault_nxt;
            r_light_q <= light;
            r_btn_q   <= ped_btn;
        end
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dw;
    assign flash       = r_flash;
    assign req_pending = r_req;
    assign countdown   = r_cnt;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_crossing_ctrl
// Description : Self-checking bench for ped_crossing_ctrl. A behavioural
//               model tracks phase and elapsed cycles, pushes the expected
//               output word at every clock edge and the result is popped and
//               compared shortly after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_crossing_ctrl;

    localparam int WALK_CYC  = 4;
    localparam int CLEAR_CYC = 3;
    localparam int FLASH_DIV = 1;
    localparam int CW        = 8;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    light;
    logic          ped_btn;
    logic          walk, dont_walk, flash, req_pending, fault;
    logic [CW-1:0] countdown;

    ped_crossing_ctrl #(
        .WALK_CYC (WALK_CYC),
        .CLEAR_CYC(CLEAR_CYC),
        .FLASH_DIV(FLASH_DIV),
        .CW       (CW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .light      (light),
        .ped_btn    (ped_btn),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .flash      (flash),
        .req_pending(req_pending),
        .countdown  (countdown),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int walk_seen = 0;

    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    // Reference model: mode 0=idle 1=walk 2=clear 3=fault, ph = cycles elapsed in phase.
    int         m_mode = 0;
    int         m_ph   = 0;
    logic       m_req  = 1'b0;
    logic [2:0] m_lq   = RED;
    logic       m_bq   = 1'b1;

    function automatic logic [15:0] model_out();
        logic       w, d, f, flt;
        logic [7:0] cd;
        w   = (m_mode == 1);
        f   = (m_mode == 2);
        flt = (m_mode == 3);
        d   = (m_mode == 1) ? 1'b0 :
              (m_mode == 2) ? (((m_ph / FLASH_DIV) % 2) == 0) : 1'b1;
        cd  = (m_mode == 1) ? 8'(WALK_CYC - m_ph) :
              (m_mode == 2) ? 8'(CLEAR_CYC - m_ph) : 8'd0;
        return {3'b000, w, d, f, m_req, flt, cd};
    endfunction

    always begin
        logic rise, rentry, legal, newreq;
        logic [15:0] e;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_ph = 0; m_req = 1'b0; m_lq = RED; m_bq = 1'b1;
        end else begin
            rise   = ped_btn & ~m_bq;
            rentry = (light == RED) && (m_lq != RED);
            legal  = (light == RED) || (light == GREEN) || (light == YELLOW);
            newreq = m_req | rise;
            m_req  = newreq;
            if (!legal) begin
                m_mode = 3;
                m_ph   = 0;
            end else begin
                case (m_mode)
                    0: if (newreq && rentry) begin m_mode = 1; m_ph = 0; m_req = 1'b0; end
                    1: if (light != RED) m_mode = 0;
                       else if (m_ph == WALK_CYC - 1) begin m_mode = 2; m_ph = 0; end
                       else m_ph++;
                    2: if (light != RED || m_ph == CLEAR_CYC - 1) begin m_mode = 0; m_ph = 0; end
                       else m_ph++;
                    default: begin m_mode = 0; m_ph = 0; end
                endcase
            end
            m_lq = light;
            m_bq = ped_btn;
        end
        exp_q.push_back(model_out());
        #1;
        e = exp_q.pop_front();
        chk("outputs", {3'b000, walk, dont_walk, flash, req_pending, fault, countdown}, e);
        chk("walk_dw_exclusive", {15'd0, walk & dont_walk}, 16'd0);
        if (walk) walk_seen++;
    end

    task automatic drive(input logic [2:0] l, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            light   = l;
            ped_btn = b;
        end
    endtask

    initial begin
        rst = 1'b1; light = RED; ped_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: press on green, full walk + clearance on red entry
        walk_seen = 0;
        drive(GREEN, 0, 3);
        drive(GREEN, 1, 1);
        drive(GREEN, 0, 1);
        drive(YELLOW, 0, 2);
        drive(RED, 0, 10);
        chk("t1_walk_cycles", 16'(walk_seen), 16'(WALK_CYC));

        // 2: no press over three light cycles
        walk_seen = 0;
        for (int k = 0; k < 3; k++) begin
            drive(GREEN, 0, 3);
            drive(YELLOW, 0, 2);
            drive(RED, 0, 4);
        end
        chk("t2_walk_cycles", 16'(walk_seen), 16'd0);

        // 3: press while already red waits for the next red entry
        walk_seen = 0;
        drive(RED, 1, 1);
        drive(RED, 0, 3);
        chk("t3_pending", {15'd0, req_pending}, 16'd1);
        chk("t3_no_walk", 16'(walk_seen), 16'd0);
        drive(GREEN, 0, 2);
        drive(YELLOW, 0, 1);
        drive(RED, 0, 8);
        chk("t3_walk_cycles", 16'(walk_seen), 16'(WALK_CYC));

        // 4: abort in walk cycle 2
        drive(GREEN, 1, 1);
        drive(GREEN, 0, 1);
        drive(YELLOW, 0, 1);
        drive(RED, 0, 2);
        drive(GREEN, 0, 2);

        // 5: illegal code during walk, then recovery without re-service
        drive(YELLOW, 1, 1);
        drive(YELLOW, 0, 1);
        drive(RED, 0, 2);
        drive(3'b110, 0, 2);
        chk("t5_fault", {15'd0, fault}, 16'd1);
        drive(RED, 0, 3);
        drive(GREEN, 0, 2);

        // 6: press coincident with red entry; reset during clearance
        drive(RED, 1, 1);
        drive(RED, 0, 2);
        drive(RED, 1, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(RED, 1, 3);
        drive(GREEN, 0, 3);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
